// File: rtl/simon_display_ctrl_pkg.sv
// Shared types and constants for the Simon display sequencer.
package simon_display_ctrl_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned FRAME_W = 8;
  localparam int unsigned BLINK_W = 4;

  localparam logic [COLOR_W-1:0] COLOR_IDLE_BG = 3'b000;
  localparam logic [COLOR_W-1:0] COLOR_OVER    = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FLASH_ON  = 3'd1,
    ST_FLASH_GAP = 3'd2,
    ST_OVER_ON   = 3'd3,
    ST_OVER_OFF  = 3'd4
  } state_t;

endpackage

// File: rtl/simon_display_ctrl_bcd2_counter.sv
// Two-digit BCD counter with synchronous clear and saturation at 99.
module bcd2_counter
  import simon_display_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] d10,
  output logic [DIGIT_W-1:0] d01
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d10 <= '0;
      d01 <= '0;
    end else if (clr) begin
      d10 <= '0;
      d01 <= '0;
    end else if (inc && !(d10 == 4'd9 && d01 == 4'd9)) begin
      if (d01 == 4'd9) begin
        d01 <= '0;
        d10 <= d10 + 4'd1;
      end else begin
        d01 <= d01 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/simon_display_ctrl.sv
// Simon display sequencer: level/max-score BCD digits, colour flashes and game-over blink.
module simon_display_ctrl
  import simon_display_ctrl_pkg::*;
#(
  parameter int unsigned         ON_FRAMES   = 30,
  parameter int unsigned         GAP_FRAMES  = 10,
  parameter int unsigned         OVER_BLINKS = 3,
  parameter logic [COLOR_W-1:0]  OVER_COLOR  = COLOR_OVER,
  parameter logic [COLOR_W-1:0]  IDLE_BG     = COLOR_IDLE_BG
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               new_game,
  input  logic               level_up,
  input  logic               game_over,
  input  logic               show_req,
  input  logic [COLOR_W-1:0] show_color,
  output logic [DIGIT_W-1:0] level_10,
  output logic [DIGIT_W-1:0] level_01,
  output logic [DIGIT_W-1:0] max_score_10,
  output logic [DIGIT_W-1:0] max_score_01,
  output logic [COLOR_W-1:0] bg,
  output logic               busy,
  output logic               show_done
);

  localparam logic [FRAME_W-1:0] ON_LAST    = FRAME_W'(ON_FRAMES - 1);
  localparam logic [FRAME_W-1:0] GAP_LAST   = FRAME_W'(GAP_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(OVER_BLINKS - 1);

  state_t             state, state_next;
  logic [FRAME_W-1:0] frame_cnt;
  logic [BLINK_W-1:0] blinks, blinks_next;
  logic [COLOR_W-1:0] color_q, color_next;
  logic [COLOR_W-1:0] bg_next;
  logic               enter, busy_next, done_next;
  logic               level_inc, max_load;

  assign level_inc = level_up && !new_game && !game_over;
  assign max_load  = game_over && !new_game &&
                     ({level_10, level_01} > {max_score_10, max_score_01});

  bcd2_counter u_level (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (level_inc),
    .clr   (new_game),
    .d10   (level_10),
    .d01   (level_01)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_score_10 <= '0;
      max_score_01 <= '0;
    end else if (max_load) begin
      max_score_10 <= level_10;
      max_score_01 <= level_01;
    end
  end

  // Outputs are registered from the next-state decode so bg/busy track state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      frame_cnt <= '0;
      blinks    <= '0;
      color_q   <= IDLE_BG;
      bg        <= IDLE_BG;
      busy      <= 1'b0;
      show_done <= 1'b0;
    end else begin
      state     <= state_next;
      blinks    <= blinks_next;
      color_q   <= color_next;
      bg        <= bg_next;
      busy      <= busy_next;
      show_done <= done_next;
      if (enter)
        frame_cnt <= '0;
      else if (frame_tick)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    state_next  = state;
    blinks_next = blinks;
    color_next  = color_q;
    enter       = 1'b0;
    done_next   = 1'b0;
    if (new_game) begin
      state_next = ST_IDLE;
      enter      = 1'b1;
    end else if (game_over) begin
      state_next  = ST_OVER_ON;
      blinks_next = '0;
      enter       = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (show_req) begin
            state_next = ST_FLASH_ON;
            color_next = show_color;
            enter      = 1'b1;
          end
        end
        ST_FLASH_ON: begin
          if (frame_tick && frame_cnt == ON_LAST) begin
            state_next = ST_FLASH_GAP;
            enter      = 1'b1;
          end
        end
        ST_FLASH_GAP: begin
          if (frame_tick && frame_cnt == GAP_LAST) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
            enter      = 1'b1;
          end
        end
        ST_OVER_ON: begin
          if (frame_tick && frame_cnt == ON_LAST) begin
            state_next = ST_OVER_OFF;
            enter      = 1'b1;
          end
        end
        ST_OVER_OFF: begin
          if (frame_tick && frame_cnt == ON_LAST) begin
            state_next  = (blinks < BLINK_LAST) ? ST_OVER_ON : ST_IDLE;
            blinks_next = blinks + 4'd1;
            enter       = 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          enter      = 1'b1;
        end
      endcase
    end

    busy_next = (state_next != ST_IDLE);
    case (state_next)
      ST_FLASH_ON: bg_next = color_next;
      ST_OVER_ON:  bg_next = OVER_COLOR;
      default:     bg_next = IDLE_BG;
    endcase
  end

endmodule

// File: doc/simon_display_ctrl.md
Name: simon_display_ctrl

Overview:
- Sequencer for the Simon colour selector: owns the BCD level and max-score digits and the `bg` colour the selector paints.
- Plays one colour flash per game-FSM request, timed in VGA frames.
- Runs a game-over blink and tracks the high score.
- Sits between the game FSM and color_selector; all outputs connect directly to the selector's `level_*`, `max_score_*` and `bg` inputs.

Parameters:
- ON_FRAMES, 30, frames `bg` shows the requested colour per flash (1..255).
- GAP_FRAMES, 10, frames of IDLE_BG after each flash before `show_done` (1..255).
- OVER_BLINKS, 3, number of OVER_COLOR blinks on game over (1..15).
- OVER_COLOR, 3'b100, `bg` colour during a game-over blink.
- IDLE_BG, 3'b000, `bg` colour when not flashing.

Ports:
- clk  in  1  system clock (pixel-domain clock shared with color_selector)
- rst_n  in  1  reset, asynchronous, active-low
- frame_tick  in  1  one-cycle pulse per VGA frame (`yvga` wrap)
- new_game  in  1  pulse: clear level, abort any sequence
- level_up  in  1  pulse: level += 1 (BCD)
- game_over  in  1  pulse: update max score, start blink sequence
- show_req  in  1  pulse: flash `show_color`
- show_color  in  3  colour to flash, sampled with `show_req`
- level_10  out  4  level tens digit (BCD)
- level_01  out  4  level ones digit (BCD)
- max_score_10  out  4  max score tens digit (BCD)
- max_score_01  out  4  max score ones digit (BCD)
- bg  out  3  background colour to color_selector
- busy  out  1  high in any state other than IDLE
- show_done  out  1  one-cycle pulse when a flash plus gap completes

Behaviour:
- **Reset:** async, on `rst_n` low.
  - All digits = 0, `bg` = IDLE_BG, `busy` = 0, `show_done` = 0, state IDLE, frame counter = 0.
- **All outputs are registered.**
- **States:**
  - IDLE: `bg` = IDLE_BG.
  - FLASH_ON: `bg` = latched colour.
  - FLASH_GAP: `bg` = IDLE_BG.
  - OVER_ON: `bg` = OVER_COLOR.
  - OVER_OFF: `bg` = IDLE_BG.
- **Frame counter (8 bit):**
  - Increments on `frame_tick` only.
  - Cleared on every state entry.
  - A state of duration N exits on the `frame_tick` that arrives when count == N-1. The state therefore lasts exactly N ticks.
- **Transitions:**
  - IDLE + `show_req` → FLASH_ON. `show_color` is latched; `bg` and `busy` update in the following cycle (latency 1).
  - FLASH_ON for ON_FRAMES → FLASH_GAP.
  - FLASH_GAP for GAP_FRAMES → IDLE, with `show_done` = 1 for exactly one cycle.
  - `game_over` from any state → OVER_ON; blink counter = 0.
  - OVER_ON for ON_FRAMES → OVER_OFF.
  - OVER_OFF for ON_FRAMES → OVER_ON if blinks done < OVER_BLINKS-1, else IDLE (blinks done increments on leaving OVER_OFF). No `show_done` is issued.
  - `new_game` from any state → IDLE; `bg` = IDLE_BG next cycle; no `show_done`.
- **Priority within one cycle:** `new_game` > `game_over` > `show_req`.
  - `level_up` is ignored when `new_game` or `game_over` is asserted in the same cycle.
  - `show_req` is ignored when `busy` = 1; no queueing.
- **Level counter:**
  - 2-digit BCD; ones wraps 9→0 with tens += 1.
  - Saturates at 99: `level_up` at 99 leaves 99.
  - `new_game` clears it to 00; the max score is retained.
  - `level_up` is accepted in any state.
- **Max score:**
  - On `game_over`, if the registered level is greater than the max (compare tens, then ones), max ← level in the next cycle.
  - An equal or lower level leaves max unchanged.
  - Max is cleared only by reset.
- **Invariant:** digits never leave 0..9.
- **Reset mid-sequence:** immediate return to reset values regardless of state.

Decomposition:
- **Shared package:**
  - state encoding (5 states, 3 bit)
  - BCD digit width (4)
  - colour width (3) and named colour constants (IDLE_BG default, OVER_COLOR default)
  - frame counter width (8)
- **Sub-module `bcd2_counter`:** 2-digit BCD register with `inc`, `clr` and saturate-at-99 outputs `d10`/`d01`.
  - Instantiated for the level counter.
  - Max score is a plain load register plus comparator in the top.

Test Plan:
1. **Reset:** assert `rst_n` = 0 mid-FLASH_ON → all digits 0, `bg` = 000, `busy` = 0 immediately, without waiting for a clock edge.
2. **Flash timing** (ON_FRAMES = 3, GAP_FRAMES = 2):
   - `show_req` with `show_color` = 3'b010 → next cycle `bg` = 010, `busy` = 1.
   - After the 3rd `frame_tick`, `bg` = 000.
   - After 2 more ticks, one-cycle `show_done`, `busy` = 0.
   - A second `show_req` while busy → no effect.
3. **BCD level:**
   - 9 `level_up` pulses → 0/9; a 10th → 1/0.
   - Continue to 99 and pulse again → stays 9/9.
   - `new_game` → 0/0.
4. **Max score:**
   - Level 12 with max 08, `game_over` → max = 1/2.
   - `new_game`, level to 05, `game_over` → max stays 1/2.
   - Same-cycle `level_up` + `game_over` at level 12 → level stays 12.
5. **Game-over blink** (OVER_BLINKS = 2, ON_FRAMES = 2):
   - `bg` sequence per 2 ticks: 100, 000, 100, 000, then IDLE.
   - `busy` falls after the 8th tick; no `show_done`.
6. **Priority:** during FLASH_ON, assert `new_game` and `game_over` in the same cycle → IDLE, `bg` = 000, level 00, no `show_done`.
